// File: rtl/cart_loader_if.sv
// rtl/cart_loader_if.sv - ioctl download bus and cartridge RAM write bus
// Purpose: groups the hps_io ioctl byte stream and the cart RAM write port.
// Ports (signals):
//   ioctl_download, ioctl_wr, ioctl_addr[24:0], ioctl_dout[7:0] : download side
//   cart_wr, cart_addr, cart_data, cart_be                      : RAM write side
// Modports: master = download source / RAM sink, slave = cart_loader.
interface cart_loader_if #(
   parameter int ADDR_W     = 15,
   parameter int WORD_BYTES = 1
);
   localparam int CA_W = ADDR_W - $clog2(WORD_BYTES);

   logic                      ioctl_download;
   logic                      ioctl_wr;
   logic [24:0]               ioctl_addr;
   logic [7:0]                ioctl_dout;

   logic                      cart_wr;
   logic [CA_W-1:0]           cart_addr;
   logic [8*WORD_BYTES-1:0]   cart_data;
   logic [WORD_BYTES-1:0]     cart_be;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      input  cart_wr, cart_addr, cart_data, cart_be
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      output cart_wr, cart_addr, cart_data, cart_be
   );
endinterface

// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - cartridge download front-end with mirror mask and skip-logo reset
// Purpose: packs ioctl bytes into 1- or 2-byte RAM words, learns the power-of-two
// mirror mask, flags out-of-range / unpaired bytes and sequences the skip-logo reset.
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   bus (slave)      : ioctl download inputs, cart RAM write outputs
//   skip_en          : skip-logo option, sampled when a download ends
//   addr_mask        : mirror mask 2^n-1
//   loaded           : last download completed with at least one accepted byte
//   size_err         : a byte of this download was beyond the cart space
//   seq_err          : an odd byte arrived without its even partner (2-byte words)
//   core_reset       : registered core reset request
module cart_loader #(
   parameter int ADDR_W     = 15,
   parameter int WORD_BYTES = 1,
   parameter int SKIP_DELAY = 4999000,
   parameter int SKIP_PULSE = 1000
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   cart_loader_if.slave      bus,
   input  logic              skip_en,
   output logic [ADDR_W-1:0] addr_mask,
   output logic              loaded,
   output logic              size_err,
   output logic              seq_err,
   output logic              core_reset
);
   localparam int CA_W    = ADDR_W - $clog2(WORD_BYTES);
   localparam int DW      = 8 * WORD_BYTES;
   localparam int CNT_MAX = (SKIP_DELAY > SKIP_PULSE) ? SKIP_DELAY : SKIP_PULSE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_PULSE = 2'd2;

   // Sets every bit at and below the highest set bit.
   function automatic logic [ADDR_W-1:0] smear(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] s;
      s = a;
      for (int i = ADDR_W - 2; i >= 0; i--) begin
         s[i] = s[i+1] | a[i];
      end
      return s;
   endfunction

   logic              dl_q, dl_d;
   logic              dl2_q, dl2_d;
   logic [ADDR_W-1:0] mask_q, mask_d;
   logic              loaded_q, loaded_d;
   logic              size_err_q, size_err_d;
   logic              seq_err_q, seq_err_d;
   logic              any_q, any_d;
   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              core_reset_q, core_reset_d;
   logic              cart_wr_q, cart_wr_d;
   logic [CA_W-1:0]   cart_addr_q, cart_addr_d;
   logic [DW-1:0]     cart_data_q, cart_data_d;
   logic [WORD_BYTES-1:0] cart_be_q, cart_be_d;

   logic dl_start, dl_fall, strobe, in_range, accept, out_of_range;

   // Packer results for the current cycle.
   logic                  pk_wr;
   logic [CA_W-1:0]       pk_addr;
   logic [DW-1:0]         pk_data;
   logic [WORD_BYTES-1:0] pk_be;
   logic                  pk_seq;

   // Start is seen against the registered copy so a byte in the very first
   // download cycle lands on already-cleared state; the end is seen one cycle
   // later so the flush and loaded appear two cycles after the fall.
   assign dl_start     = bus.ioctl_download & ~dl_q;
   assign dl_fall      = dl2_q & ~dl_q;
   assign strobe       = bus.ioctl_wr & bus.ioctl_download;
   assign in_range     = (bus.ioctl_addr[24:ADDR_W] == '0);
   assign accept       = strobe & in_range;
   assign out_of_range = strobe & ~in_range;

   generate
      if (WORD_BYTES == 2) begin : g_word2
         logic            pend_valid_q, pend_valid_d;
         logic [7:0]      pend_data_q, pend_data_d;
         logic [CA_W-1:0] pend_addr_q, pend_addr_d;
         logic [CA_W-1:0] waddr;

         assign waddr = bus.ioctl_addr[ADDR_W-1:1];

         always_comb begin
            pend_valid_d = pend_valid_q;
            pend_data_d  = pend_data_q;
            pend_addr_d  = pend_addr_q;
            pk_wr        = 1'b0;
            pk_addr      = pend_addr_q;
            pk_data      = '0;
            pk_be        = 2'b00;
            pk_seq       = 1'b0;
            if (dl_fall && pend_valid_q) begin
               pk_wr        = 1'b1;
               pk_data      = {8'h00, pend_data_q};
               pk_be        = 2'b01;
               pend_valid_d = 1'b0;
            end
            if (dl_start) begin
               pend_valid_d = 1'b0;
            end
            if (accept) begin
               if (!bus.ioctl_addr[0]) begin
                  if (pend_valid_d) begin
                     pk_wr   = 1'b1;
                     pk_addr = pend_addr_q;
                     pk_data = {8'h00, pend_data_q};
                     pk_be   = 2'b01;
                  end
                  pend_valid_d = 1'b1;
                  pend_data_d  = bus.ioctl_dout;
                  pend_addr_d  = waddr;
               end else if (pend_valid_d && (pend_addr_q == waddr)) begin
                  pk_wr        = 1'b1;
                  pk_addr      = waddr;
                  pk_data      = {bus.ioctl_dout, pend_data_q};
                  pk_be        = 2'b11;
                  pend_valid_d = 1'b0;
               end else begin
                  pk_wr        = 1'b1;
                  pk_addr      = waddr;
                  pk_data      = {bus.ioctl_dout, 8'h00};
                  pk_be        = 2'b10;
                  pk_seq       = 1'b1;
                  pend_valid_d = 1'b0;
               end
            end
         end

         always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
               pend_valid_q <= 1'b0;
               pend_data_q  <= '0;
               pend_addr_q  <= '0;
            end else begin
               pend_valid_q <= pend_valid_d;
               pend_data_q  <= pend_data_d;
               pend_addr_q  <= pend_addr_d;
            end
         end
      end else begin : g_word1
         assign pk_wr   = accept;
         assign pk_addr = bus.ioctl_addr[ADDR_W-1:0];
         assign pk_data = bus.ioctl_dout;
         assign pk_be   = 1'b1;
         assign pk_seq  = 1'b0;
      end
   endgenerate

   always_comb begin
      dl_d        = bus.ioctl_download;
      dl2_d       = dl_q;
      mask_d      = mask_q;
      loaded_d    = loaded_q;
      size_err_d  = size_err_q;
      seq_err_d   = seq_err_q;
      any_d       = any_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      cart_wr_d   = pk_wr;
      cart_addr_d = pk_wr ? pk_addr : cart_addr_q;
      cart_data_d = pk_wr ? pk_data : cart_data_q;
      cart_be_d   = pk_wr ? pk_be   : cart_be_q;

      if (dl_fall && any_q) begin
         loaded_d = 1'b1;
      end
      if (dl_start) begin
         mask_d     = '0;
         loaded_d   = 1'b0;
         size_err_d = 1'b0;
         seq_err_d  = 1'b0;
         any_d      = 1'b0;
      end
      if (accept) begin
         mask_d = mask_d | smear(bus.ioctl_addr[ADDR_W-1:0]);
         any_d  = 1'b1;
      end
      if (out_of_range) begin
         size_err_d = 1'b1;
      end
      if (pk_seq) begin
         seq_err_d = 1'b1;
      end

      // cnt_q holds the cycles remaining in WAIT/PULSE, including the current one.
      case (state_q)
         ST_IDLE: begin
            if (dl_fall && skip_en) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(SKIP_DELAY);
            end
         end
         ST_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_PULSE;
               cnt_d   = CNT_W'(SKIP_PULSE);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_PULSE: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (dl_start) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end

      // Keyed on the next state so the flop is high exactly while PULSE lasts.
      core_reset_d = bus.ioctl_download | (state_d == ST_PULSE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dl_q         <= 1'b0;
         dl2_q        <= 1'b0;
         mask_q       <= '0;
         loaded_q     <= 1'b0;
         size_err_q   <= 1'b0;
         seq_err_q    <= 1'b0;
         any_q        <= 1'b0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         core_reset_q <= 1'b0;
         cart_wr_q    <= 1'b0;
         cart_addr_q  <= '0;
         cart_data_q  <= '0;
         cart_be_q    <= '0;
      end else begin
         dl_q         <= dl_d;
         dl2_q        <= dl2_d;
         mask_q       <= mask_d;
         loaded_q     <= loaded_d;
         size_err_q   <= size_err_d;
         seq_err_q    <= seq_err_d;
         any_q        <= any_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         core_reset_q <= core_reset_d;
         cart_wr_q    <= cart_wr_d;
         cart_addr_q  <= cart_addr_d;
         cart_data_q  <= cart_data_d;
         cart_be_q    <= cart_be_d;
      end
   end

   assign bus.cart_wr   = cart_wr_q;
   assign bus.cart_addr = cart_addr_q;
   assign bus.cart_data = cart_data_q;
   assign bus.cart_be   = cart_be_q;
   assign addr_mask     = mask_q;
   assign loaded        = loaded_q;
   assign size_err      = size_err_q;
   assign seq_err       = seq_err_q;
   assign core_reset    = core_reset_q;
endmodule

// File: tb/tb_cart_loader.sv
// tb/tb_cart_loader.sv - directed self-checking bench for cart_loader (1- and 2-byte words)
module tb_cart_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   cart_loader_if #(.ADDR_W(15), .WORD_BYTES(1)) bus1 ();
   cart_loader_if #(.ADDR_W(15), .WORD_BYTES(2)) bus2 ();

   logic        skip_en1, skip_en2;
   logic [14:0] mask1, mask2;
   logic        loaded1, loaded2, size_err1, size_err2, seq_err1, seq_err2;
   logic        core_reset1, core_reset2;

   cart_loader #(.ADDR_W(15), .WORD_BYTES(1), .SKIP_DELAY(10), .SKIP_PULSE(3)) u1 (
      .clk_sys(clk), .reset_n(rst_n), .bus(bus1), .skip_en(skip_en1),
      .addr_mask(mask1), .loaded(loaded1), .size_err(size_err1),
      .seq_err(seq_err1), .core_reset(core_reset1)
   );

   cart_loader #(.ADDR_W(15), .WORD_BYTES(2), .SKIP_DELAY(10), .SKIP_PULSE(3)) u2 (
      .clk_sys(clk), .reset_n(rst_n), .bus(bus2), .skip_en(skip_en2),
      .addr_mask(mask2), .loaded(loaded2), .size_err(size_err2),
      .seq_err(seq_err2), .core_reset(core_reset2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr1(input logic [24:0] a, input logic [7:0] d);
      bus1.ioctl_wr = 1'b1; bus1.ioctl_addr = a; bus1.ioctl_dout = d;
      tick();
      bus1.ioctl_wr = 1'b0;
   endtask

   task automatic wr2(input logic [24:0] a, input logic [7:0] d);
      bus2.ioctl_wr = 1'b1; bus2.ioctl_addr = a; bus2.ioctl_dout = d;
      tick();
      bus2.ioctl_wr = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      skip_en1 = 1'b0; skip_en2 = 1'b0;
      bus1.ioctl_download = 1'b1; bus1.ioctl_wr = 1'b1; bus1.ioctl_addr = '0; bus1.ioctl_dout = '0;
      bus2.ioctl_download = 1'b0; bus2.ioctl_wr = 1'b0; bus2.ioctl_addr = '0; bus2.ioctl_dout = '0;
      tick(); tick();
      checks++; if (core_reset1 !== 1'b0) begin errors++; $display("FAIL reset_core_reset: got %b want 0", core_reset1); end
      checks++; if (bus1.cart_wr !== 1'b0) begin errors++; $display("FAIL reset_cart_wr: got %b want 0", bus1.cart_wr); end
      checks++; if (mask1 !== 15'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", mask1); end
      checks++; if ({loaded1, size_err1, seq_err1, loaded2, size_err2, seq_err2} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 000000", {loaded1, size_err1, seq_err1, loaded2, size_err2, seq_err2}); end
      bus1.ioctl_download = 1'b0; bus1.ioctl_wr = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_w1_sequential;
      int bad, nwr;
      bad = 0; nwr = 0;
      bus1.ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 8192; i++) begin
         bus1.ioctl_wr = 1'b1; bus1.ioctl_addr = 25'(i); bus1.ioctl_dout = 8'(i) ^ 8'h5A;
         tick();
         if (bus1.cart_wr === 1'b1) nwr++;
         if (bus1.cart_wr !== 1'b1 || bus1.cart_addr !== 15'(i) ||
             bus1.cart_data !== (8'(i) ^ 8'h5A) || bus1.cart_be !== 1'b1) bad++;
      end
      bus1.ioctl_wr = 1'b0;
      checks++; if (nwr !== 8192) begin errors++; $display("FAIL w1_write_count: got %0d want 8192", nwr); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL w1_write_content: got %0d bad writes want 0", bad); end
      checks++; if (mask1 !== 15'h1FFF) begin errors++; $display("FAIL w1_mask: got %h want 1fff", mask1); end
      checks++; if (size_err1 !== 1'b0) begin errors++; $display("FAIL w1_size_err: got %b want 0", size_err1); end
      bus1.ioctl_download = 1'b0;
      tick();
      checks++; if (loaded1 !== 1'b0) begin errors++; $display("FAIL w1_loaded_early: got %b want 0", loaded1); end
      tick();
      checks++; if (loaded1 !== 1'b1) begin errors++; $display("FAIL w1_loaded: got %b want 1", loaded1); end
      tick();
   endtask

   task automatic test_mask_and_size;
      bus1.ioctl_download = 1'b1;
      tick();
      checks++; if (mask1 !== 15'h0 || loaded1 !== 1'b0) begin
         errors++; $display("FAIL start_clear: got mask %h loaded %b want 0 0", mask1, loaded1); end
      wr1(25'h2100, 8'h42);
      checks++; if (bus1.cart_wr !== 1'b1 || bus1.cart_addr !== 15'h2100 || bus1.cart_data !== 8'h42) begin
         errors++; $display("FAIL single_write: got wr %b addr %h data %h want 1 2100 42", bus1.cart_wr, bus1.cart_addr, bus1.cart_data); end
      checks++; if (mask1 !== 15'h3FFF) begin errors++; $display("FAIL single_mask: got %h want 3fff", mask1); end
      checks++; if (size_err1 !== 1'b0) begin errors++; $display("FAIL single_size_err: got %b want 0", size_err1); end
      wr1(25'h8000, 8'h99);
      checks++; if (bus1.cart_wr !== 1'b0) begin errors++; $display("FAIL oor_no_write: got %b want 0", bus1.cart_wr); end
      checks++; if (size_err1 !== 1'b1) begin errors++; $display("FAIL oor_size_err: got %b want 1", size_err1); end
      checks++; if (mask1 !== 15'h3FFF) begin errors++; $display("FAIL oor_mask: got %h want 3fff", mask1); end
      bus1.ioctl_download = 1'b0;
      tick(); tick();
      checks++; if (loaded1 !== 1'b1 || size_err1 !== 1'b1) begin
         errors++; $display("FAIL oor_end: got loaded %b size_err %b want 1 1", loaded1, size_err1); end
      tick();
   endtask

   task automatic test_w2_pack;
      bus2.ioctl_download = 1'b1;
      tick();
      wr2(25'd0, 8'hAA);
      checks++; if (bus2.cart_wr !== 1'b0) begin errors++; $display("FAIL w2_even_held: got %b want 0", bus2.cart_wr); end
      wr2(25'd1, 8'hBB);
      checks++; if (bus2.cart_wr !== 1'b1 || bus2.cart_addr !== 14'd0 || bus2.cart_data !== 16'hBBAA || bus2.cart_be !== 2'b11) begin
         errors++; $display("FAIL w2_pair: got wr %b addr %h data %h be %b want 1 0 bbaa 11", bus2.cart_wr, bus2.cart_addr, bus2.cart_data, bus2.cart_be); end
      wr2(25'd4, 8'h33);
      wr2(25'd6, 8'h44);
      checks++; if (bus2.cart_wr !== 1'b1 || bus2.cart_addr !== 14'd2 || bus2.cart_data !== 16'h0033 || bus2.cart_be !== 2'b01) begin
         errors++; $display("FAIL w2_even_flush: got wr %b addr %h data %h be %b want 1 2 0033 01", bus2.cart_wr, bus2.cart_addr, bus2.cart_data, bus2.cart_be); end
      wr2(25'd7, 8'h55);
      checks++; if (bus2.cart_wr !== 1'b1 || bus2.cart_addr !== 14'd3 || bus2.cart_data !== 16'h5544 || bus2.cart_be !== 2'b11) begin
         errors++; $display("FAIL w2_pair2: got wr %b addr %h data %h be %b want 1 3 5544 11", bus2.cart_wr, bus2.cart_addr, bus2.cart_data, bus2.cart_be); end
      wr2(25'd2, 8'hCC);
      bus2.ioctl_download = 1'b0;
      tick();
      checks++; if (bus2.cart_wr !== 1'b0) begin errors++; $display("FAIL w2_flush_early: got %b want 0", bus2.cart_wr); end
      tick();
      checks++; if (bus2.cart_wr !== 1'b1 || bus2.cart_addr !== 14'd1 || bus2.cart_data !== 16'h00CC || bus2.cart_be !== 2'b01) begin
         errors++; $display("FAIL w2_end_flush: got wr %b addr %h data %h be %b want 1 1 00cc 01", bus2.cart_wr, bus2.cart_addr, bus2.cart_data, bus2.cart_be); end
      checks++; if (loaded2 !== 1'b1 || seq_err2 !== 1'b0 || mask2 !== 15'h7) begin
         errors++; $display("FAIL w2_status: got loaded %b seq_err %b mask %h want 1 0 0007", loaded2, seq_err2, mask2); end
      tick();
      checks++; if (bus2.cart_wr !== 1'b0) begin errors++; $display("FAIL w2_flush_width: got %b want 0", bus2.cart_wr); end
   endtask

   task automatic test_w2_seq_err;
      bus2.ioctl_download = 1'b1;
      tick();
      wr2(25'd1, 8'h77);
      checks++; if (bus2.cart_wr !== 1'b1 || bus2.cart_addr !== 14'd0 || bus2.cart_data !== 16'h7700 || bus2.cart_be !== 2'b10) begin
         errors++; $display("FAIL w2_lone_odd: got wr %b addr %h data %h be %b want 1 0 7700 10", bus2.cart_wr, bus2.cart_addr, bus2.cart_data, bus2.cart_be); end
      checks++; if (seq_err2 !== 1'b1) begin errors++; $display("FAIL w2_seq_err: got %b want 1", seq_err2); end
      wr2(25'd2, 8'h11);
      wr2(25'd5, 8'h22);
      checks++; if (bus2.cart_wr !== 1'b1 || bus2.cart_addr !== 14'd2 || bus2.cart_data !== 16'h2200 || bus2.cart_be !== 2'b10) begin
         errors++; $display("FAIL w2_other_word: got wr %b addr %h data %h be %b want 1 2 2200 10", bus2.cart_wr, bus2.cart_addr, bus2.cart_data, bus2.cart_be); end
      bus2.ioctl_download = 1'b0;
      tick(); tick();
      checks++; if (bus2.cart_wr !== 1'b0) begin errors++; $display("FAIL w2_dropped_no_flush: got %b want 0", bus2.cart_wr); end
      tick();
   endtask

   task automatic test_reset_mid;
      bus2.ioctl_download = 1'b1;
      tick();
      checks++; if (seq_err2 !== 1'b0) begin errors++; $display("FAIL start_clears_seq_err: got %b want 0", seq_err2); end
      wr2(25'h10, 8'h55);
      checks++; if (mask2 !== 15'h1F) begin errors++; $display("FAIL mid_mask: got %h want 001f", mask2); end
      rst_n = 1'b0;
      #1;
      checks++; if (mask2 !== 15'h0 || core_reset2 !== 1'b0) begin
         errors++; $display("FAIL async_reset: got mask %h core_reset %b want 0 0", mask2, core_reset2); end
      tick();
      bus2.ioctl_download = 1'b0;
      rst_n = 1'b1;
      tick(); tick(); tick();
      checks++; if (bus2.cart_wr !== 1'b0 || loaded2 !== 1'b0) begin
         errors++; $display("FAIL reset_no_flush: got wr %b loaded %b want 0 0", bus2.cart_wr, loaded2); end
   endtask

   task automatic test_skip;
      logic [20:1] seen, want;
      skip_en1 = 1'b1;
      bus1.ioctl_download = 1'b1;
      tick();
      wr1(25'd3, 8'h01);
      bus1.ioctl_download = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         seen[c] = core_reset1;
         want[c] = (c >= 12 && c <= 14);
      end
      checks++; if (seen !== want) begin errors++; $display("FAIL skip_pulse: got %b want %b", seen, want); end
      skip_en1 = 1'b0;
      tick();
   endtask

   task automatic test_skip_abort;
      logic [20:1] seen, want;
      skip_en1 = 1'b1;
      bus1.ioctl_download = 1'b1;
      tick();
      wr1(25'd3, 8'h01);
      bus1.ioctl_download = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         seen[c] = core_reset1;
         want[c] = (c == 6 || c == 7);
         if (c == 5) bus1.ioctl_download = 1'b1;
         if (c == 7) begin
            bus1.ioctl_download = 1'b0;
            skip_en1 = 1'b0;
         end
      end
      checks++; if (seen !== want) begin errors++; $display("FAIL skip_abort: got %b want %b", seen, want); end
      checks++; if (loaded1 !== 1'b0) begin errors++; $display("FAIL empty_download_loaded: got %b want 0", loaded1); end
   endtask

   initial begin
      test_reset();
      test_w1_sequential();
      test_mask_and_size();
      test_w2_pack();
      test_w2_seq_err();
      test_reset_mid();
      test_skip();
      test_skip_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
